// File: rtl/data_mem_arbiter.sv
// Data RAM arbiter between the ME-stage CPU port (default winner) and the serial
// debug/loader port, with a starvation counter that forces a debug grant.
module data_mem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 8,
  parameter int CNTW     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wd,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [WIDTH-1:0] dbg_addr,
  input  logic [WIDTH-1:0] dbg_wd,
  output logic             dbg_ack,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    DBG_ACK = 1'b1
  } state_t;

  localparam logic [CNTW-1:0] MAX_WAIT_C = CNTW'(MAX_WAIT);
  localparam logic [CNTW-1:0] ONE_C      = CNTW'(1);
  localparam logic [CNTW-1:0] ZERO_C     = CNTW'(0);

  state_t           state_q, state_d;
  logic [CNTW-1:0]  wait_cnt_q, wait_cnt_d;
  logic             dbg_ack_q, dbg_ack_d;
  logic [WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic             dbg_grant_s;
  logic             cpu_grant_s;
  logic             wait_full_s;

  assign wait_full_s = (wait_cnt_q == MAX_WAIT_C);

  // Grant decision; reset suppresses both grants so no RAM write or stall escapes.
  always_comb begin
    dbg_grant_s = 1'b0;
    cpu_grant_s = 1'b0;
    if (reset) begin
      dbg_grant_s = 1'b0;
      cpu_grant_s = 1'b0;
    end else begin
      if ((state_q == IDLE) && dbg_req && (!cpu_req || wait_full_s)) begin
        dbg_grant_s = 1'b1;
      end else begin
        dbg_grant_s = 1'b0;
      end
      cpu_grant_s = cpu_req & ~dbg_grant_s;
    end
  end

  // RAM port mux and pipeline stall.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wd    = cpu_wd;
    mem_we    = 1'b0;
    cpu_stall = 1'b0;
    if (dbg_grant_s) begin
      mem_addr  = dbg_addr;
      mem_wd    = dbg_wd;
      mem_we    = dbg_we;
      cpu_stall = cpu_req;
    end else begin
      mem_addr  = cpu_addr;
      mem_wd    = cpu_wd;
      mem_we    = cpu_grant_s & cpu_we;
      cpu_stall = 1'b0;
    end
  end

  // Next-state logic: ack follows a grant by one cycle, wait counter tracks losses.
  always_comb begin
    state_d     = IDLE;
    wait_cnt_d  = ZERO_C;
    dbg_ack_d   = dbg_grant_s;
    dbg_rdata_d = dbg_rdata_q;
    if (dbg_grant_s) begin
      dbg_rdata_d = mem_rdata;
    end else begin
      dbg_rdata_d = dbg_rdata_q;
    end
    case (state_q)
      IDLE: begin
        if (dbg_grant_s) begin
          state_d    = DBG_ACK;
          wait_cnt_d = ZERO_C;
        end else if (dbg_req) begin
          state_d    = IDLE;
          wait_cnt_d = wait_full_s ? wait_cnt_q : (wait_cnt_q + ONE_C);
        end else begin
          state_d    = IDLE;
          wait_cnt_d = ZERO_C;
        end
      end
      DBG_ACK: begin
        state_d    = IDLE;
        wait_cnt_d = ZERO_C;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = ZERO_C;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= ZERO_C;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // A reset in the ack cycle drops the pending ack immediately.
  assign dbg_ack   = dbg_ack_q & ~reset;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_rdata = mem_rdata;

  data_mem_arbiter_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .dbg_req   (dbg_req),
    .cpu_stall (cpu_stall),
    .dbg_ack   (dbg_ack),
    .mem_we    (mem_we)
  );

endmodule

// Protocol properties of the arbiter outputs.
module data_mem_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic dbg_req,
  input logic cpu_stall,
  input logic dbg_ack,
  input logic mem_we
);

  a_ack_single: assert property (@(posedge clk) disable iff (reset) dbg_ack |=> !dbg_ack);
  a_stall_dbg:  assert property (@(posedge clk) cpu_stall |-> dbg_req);
  a_reset_quiet: assert property (@(posedge clk) reset |-> (!mem_we && !cpu_stall && !dbg_ack));

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs, a negedge
// monitor pops and compares them against the DUT driving a behavioural RAM.
module tb_data_mem_arbiter;
  localparam int W  = 32;
  localparam int MW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, cpu_req, cpu_we, dbg_req, dbg_we;
  logic [W-1:0] cpu_addr, cpu_wd, dbg_addr, dbg_wd;
  logic [W-1:0] cpu_rdata, dbg_rdata, mem_addr, mem_wd, mem_rdata;
  logic         cpu_stall, dbg_ack, mem_we;

  data_mem_arbiter #(.WIDTH(W), .MAX_WAIT(MW), .CNTW(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rdata(mem_rdata)
  );

  // Behavioural RAM: combinational read, write at the clock edge.
  logic [W-1:0] ram [0:255] = '{default: 32'h0};
  assign mem_rdata = ram[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:0]] <= mem_wd;

  // Reference model state.
  logic [W-1:0] ref_mem [0:255] = '{default: 32'h0};
  int           m_wait = 0;
  bit           m_ack  = 1'b0;
  logic [W-1:0] m_rd   = 32'h0;

  typedef struct {
    bit           rst;
    bit           ack;
    bit           stall;
    bit           we;
    logic [W-1:0] addr;
    logic [W-1:0] wd;
    logic [W-1:0] drd;
    bit           cchk;
    logic [W-1:0] crd;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Predict this cycle's outputs from current inputs, queue them, advance the model.
  task automatic apply();
    exp_t e;
    bit   g, cg;
    if (reset) begin
      g  = 1'b0;
      cg = 1'b0;
    end else begin
      g  = !m_ack && dbg_req && (!cpu_req || m_wait >= MW);
      cg = cpu_req && !g;
    end
    e.rst   = reset;
    e.ack   = m_ack && !reset;
    e.stall = g && cpu_req;
    e.we    = g ? dbg_we : (cg && cpu_we);
    e.addr  = g ? dbg_addr : cpu_addr;
    e.wd    = g ? dbg_wd : cpu_wd;
    e.drd   = m_rd;
    e.cchk  = cg && !cpu_we;
    e.crd   = ref_mem[cpu_addr[7:0]];
    exp_q.push_back(e);
    if (reset) begin
      m_wait = 0;
      m_ack  = 1'b0;
      m_rd   = 32'h0;
    end else begin
      if (g) begin
        m_rd = ref_mem[dbg_addr[7:0]];
        if (dbg_we) ref_mem[dbg_addr[7:0]] = dbg_wd;
      end else if (cg && cpu_we) begin
        ref_mem[cpu_addr[7:0]] = cpu_wd;
      end
      if (g || !dbg_req || m_ack) m_wait = 0;
      else if (m_wait < MW) m_wait++;
      m_ack = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input bit r, input bit we, input logic [W-1:0] a, input logic [W-1:0] d);
    cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wd = d;
  endtask

  task automatic set_dbg(input bit r, input bit we, input logic [W-1:0] a, input logic [W-1:0] d);
    dbg_req = r; dbg_we = we; dbg_addr = a; dbg_wd = d;
  endtask

  function automatic logic [W-1:0] raddr();
    logic [15:0] hi;
    logic [7:0]  lo;
    hi = 16'($urandom);
    lo = 8'($urandom_range(0, 31));
    return {hi, 8'h00, lo};
  endfunction

  // Monitor: compare every DUT cycle against the queued prediction.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("dbg_ack",   {31'h0, dbg_ack},   {31'h0, mon_e.ack});
      chk("cpu_stall", {31'h0, cpu_stall}, {31'h0, mon_e.stall});
      chk("mem_we",    {31'h0, mem_we},    {31'h0, mon_e.we});
      chk("dbg_rdata", dbg_rdata, mon_e.drd);
      if (!mon_e.rst) begin
        chk("mem_addr", mem_addr, mon_e.addr);
        chk("mem_wd",   mem_wd,   mon_e.wd);
      end
      if (mon_e.cchk) chk("cpu_rdata", cpu_rdata, mon_e.crd);
    end
  end

  bit dbg_active, hold_ack;

  initial begin
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    apply();
    apply();
    reset = 1'b0;

    // CPU store then load with the debug port idle.
    set_cpu(1'b1, 1'b1, 32'h10, 32'hDEADBEEF); apply();
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);        apply();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);         apply();

    // Debug write then read back with the CPU idle.
    set_dbg(1'b1, 1'b1, 32'h20, 32'h12345678); apply();
    apply();
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0);         apply();
    set_dbg(1'b1, 1'b0, 32'h20, 32'h0);        apply();
    apply();
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0);         apply();

    // Both requesters held: force grant after MAX_WAIT losses.
    set_cpu(1'b1, 1'b0, 32'h20, 32'h0);
    set_dbg(1'b1, 1'b1, 32'h14, 32'hCAFEF00D);
    for (int i = 0; i < 20 && !m_ack; i++) apply();
    apply();
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0); apply();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0); apply();

    // Debug held continuously, CPU idle: one grant every two cycles.
    set_dbg(1'b1, 1'b0, 32'h14, 32'h0);
    repeat (8) apply();
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0); apply();

    // Reset in the ack cycle drops the ack and clears dbg_rdata.
    set_dbg(1'b1, 1'b1, 32'h18, 32'h0BADC0DE); apply();
    reset = 1'b1; apply();
    reset = 1'b0;
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0); apply(); apply();

    // A one-cycle drop of dbg_req restarts the starvation count.
    set_cpu(1'b1, 1'b1, 32'h04, 32'h55AA55AA);
    set_dbg(1'b1, 1'b0, 32'h18, 32'h0);
    repeat (5) apply();
    dbg_req = 1'b0; apply();
    dbg_req = 1'b1;
    for (int i = 0; i < 20 && !m_ack; i++) apply();
    apply();
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0); apply();

    // Randomized traffic with a protocol-following debug agent.
    dbg_active = 1'b0;
    hold_ack   = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!dbg_active && $urandom_range(0, 2) == 0) begin
        dbg_active = 1'b1;
        set_dbg(1'b1, 1'($urandom), raddr(), $urandom());
      end
      dbg_req = dbg_active | hold_ack;
      hold_ack = 1'b0;
      set_cpu($urandom_range(0, 3) != 0, 1'($urandom), raddr(), $urandom());
      reset = ($urandom_range(0, 99) == 0);
      apply();
      if (reset) dbg_active = 1'b0;
      else if (m_ack) begin
        dbg_active = 1'b0;
        hold_ack   = 1'($urandom);
      end
    end
    reset = 1'b0;
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    apply();
    @(negedge clk);
    @(negedge clk);
    chk("queue_drain", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data RAM between two requesters: the CPU pipeline memory stage (primary) and the serial debug/loader port (secondary).
- Sits between the ME-stage address/write-data/load-store controls and the data RAM instance.
- The CPU wins by default. A starvation counter forces a debug access after a bounded wait. During that cycle the block raises a stall to the pipeline.

Parameters:
- WIDTH, 32, data and address width.
- MAX_WAIT, 8, number of consecutive losing cycles for the debug requester before it is force-granted.
- CNTW, 4, width of the wait counter. Must satisfy 2^CNTW > MAX_WAIT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_req  input  1  ME stage holds a valid load/store this cycle.
- cpu_we  input  1  1 = store, 0 = load.
- cpu_addr  input  WIDTH  ME-stage address (ALU result).
- cpu_wd  input  WIDTH  store data.
- cpu_rdata  output  WIDTH  load data to the MEWB register; equals mem_rdata.
- cpu_stall  output  1  hold fetch/reg/EX/ME pipeline registers this cycle.
- dbg_req  input  1  debug access request; level, held until dbg_ack.
- dbg_we  input  1  debug write enable.
- dbg_addr  input  WIDTH  debug address.
- dbg_wd  input  WIDTH  debug write data.
- dbg_ack  output  1  one-cycle completion pulse.
- dbg_rdata  output  WIDTH  debug read data; valid while dbg_ack = 1.
- mem_we  output  1  RAM write enable.
- mem_addr  output  WIDTH  RAM read/write address.
- mem_wd  output  WIDTH  RAM write data.
- mem_rdata  input  WIDTH  RAM read data. Read is combinational on mem_addr; write commits at the clock edge.

Behaviour:
- FSM states: IDLE, DBG_ACK.
- Registered state: wait_cnt (CNTW bits), dbg_ack, dbg_rdata.
- Reset (synchronous, highest priority):
  - state = IDLE, wait_cnt = 0, dbg_ack = 0, dbg_rdata = 0.
  - While reset = 1: mem_we = 0 and cpu_stall = 0.
- Debug grant (combinational): dbg_grant = (state == IDLE) & dbg_req & (~cpu_req | wait_cnt == MAX_WAIT).
- CPU grant: cpu_grant = cpu_req & ~dbg_grant.
- cpu_stall = dbg_grant & cpu_req. This is combinational, same cycle; the pipeline re-presents the identical request next cycle.
- RAM mux:
  - When dbg_grant: mem_addr = dbg_addr, mem_wd = dbg_wd, mem_we = dbg_we.
  - Otherwise: mem_addr = cpu_addr, mem_wd = cpu_wd, mem_we = cpu_grant & cpu_we.
  - With no request, mem_we = 0 and mem_addr = cpu_addr.
- cpu_rdata = mem_rdata at all times. It is meaningful only when cpu_grant = 1.
- Debug access latency:
  - Grant in cycle N: the RAM access happens in cycle N, and dbg_rdata latches mem_rdata at the edge ending N.
  - In cycle N+1: dbg_ack = 1 and state = DBG_ACK.
  - DBG_ACK always returns to IDLE after one cycle. dbg_ack is 0 in every other cycle.
  - In DBG_ACK, dbg_req is ignored, since it may still be high while the requester drops it. The CPU has the RAM unconditionally in DBG_ACK, so back-to-back debug accesses are at most one every 2 cycles.
- Write via debug: dbg_rdata latches the pre-write RAM contents. This is don't-care for the requester.
- wait_cnt update:
  - In IDLE with dbg_req & ~dbg_grant: wait_cnt increments, saturating at MAX_WAIT.
  - On dbg_grant: cleared to 0.
  - In IDLE with dbg_req = 0: cleared to 0.
  - In DBG_ACK: held at 0.
- Forced grant: after MAX_WAIT consecutive losing cycles, the next IDLE cycle grants debug even with cpu_req = 1. At most one stall cycle per debug access.
- Simultaneous cpu_req and dbg_req with wait_cnt < MAX_WAIT: the CPU wins with no stall.
- Reset during DBG_ACK, or in the cycle after a grant: the pending ack is dropped (dbg_ack = 0). A debug write already committed at the prior edge stays in RAM.
- The CPU is never stalled when dbg_req = 0. Pipeline behaviour with the debug port idle is identical to a direct RAM connection.

Test Plan:
- Debug idle, CPU store 0xDEADBEEF to 0x10 then load 0x10 -> mem_we = 1 for the store cycle, cpu_rdata = 0xDEADBEEF on the load, cpu_stall = 0 throughout.
- CPU idle, debug write 0x12345678 to 0x20 in cycle N -> mem_we = 1 and mem_addr = 0x20 in N, dbg_ack = 1 in N+1 only. Then debug read 0x20 -> dbg_rdata = 0x12345678 with dbg_ack.
- cpu_req and dbg_req both held high from cycle 0 -> CPU granted cycles 0–7 (wait_cnt 0→8). In cycle 8, dbg_grant = 1 and cpu_stall = 1 for exactly one cycle. dbg_ack in cycle 9, where the CPU is granted with no stall.
- dbg_req held high continuously with CPU idle -> grants in cycles 0, 2, 4, …; dbg_ack in 1, 3, 5, …; no grant ever issued in a DBG_ACK cycle.
- Debug granted in cycle 5, reset asserted in cycle 6 -> dbg_ack = 0 in cycle 6; state IDLE, wait_cnt = 0, dbg_rdata = 0 in cycle 7.
- dbg_req pulses off for one cycle after 5 losing cycles -> wait_cnt clears to 0, and the force-grant occurs only after 8 new consecutive losses.
